// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encodings and
// the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must be at least one bit wide even when WIDTH is 1.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR on the carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0_s;
  logic c0_s;
  logic c1_s;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0_s),
    .carry (c0_s)
  );

  half_adder u_ha1 (
    .a     (s0_s),
    .b     (cin),
    .sum   (sum),
    .carry (c1_s)
  );

  assign cout = c0_s | c1_s;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell shared by the serial adder datapath.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: walks WIDTH-bit operands LSB-first through one
// shared full adder, with valid/ready handshakes on both sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nxt_s;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             accept_s;
  logic             last_s;

  full_adder u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // New sum bit enters at the MSB so bit i lands at sum[i] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_nxt_s = fa_sum_s;
    end else begin : g_sum_wn
      assign sum_nxt_s = {fa_sum_s, sum_r[WIDTH-1:1]};
    end
  endgenerate

  assign accept_s = in_valid & in_ready;
  assign last_s   = (cnt_r == LAST);
  assign sum      = sum_r;
  assign cout     = cout_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready && in_valid) state_nxt_s = ST_RUN;
        else if (out_ready)        state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_RUN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Operand load on accept, one adder step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          sum_r   <= sum_nxt_s;
          carry_r <= fa_cout_s;
          cnt_r   <= cnt_r + CW'(1'b1);
          if (last_s) cout_r <= fa_cout_s;
        end
        default: begin
          // Result registers stay frozen here; only a fresh accept reloads.
          if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= {CW{1'b0}};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: 8-bit and 1-bit instances against
// a plain-arithmetic reference model.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
  logic [0:0] a1, b1, sum1;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;
  logic [8:0] hold_v;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
    .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1),
    .busy(busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the oldest expected result whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (q8.size() == 0) begin
        check("unexpected_result8", 64'(1'b1), 64'(1'b0));
      end else begin
        e8 = q8.pop_front();
        check("result8", 64'({cout8, sum8}), 64'(e8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      if (q1.size() == 0) begin
        check("unexpected_result1", 64'(1'b1), 64'(1'b0));
      end else begin
        e1 = q1.pop_front();
        check("result1", 64'({cout1, sum1}), 64'(e1));
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit retire);
    int k;
    int lat;
    iv8  = 1'b1;
    a8   = a;
    b8   = b;
    cin8 = c;
    k    = 0;
    #1;
    while (!ir8 && k < 50) begin
      step();
      #1;
      k++;
    end
    check("accept_ready", 64'(ir8), 64'(1'b1));
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    step();
    iv8 = 1'b0;
    lat = 0;
    #1;
    while (!ov8 && lat < 40) begin
      check("busy_run", 64'(busy8), 64'(1'b1));
      check("in_ready_run", 64'(ir8), 64'(1'b0));
      step();
      #1;
      lat++;
    end
    check("latency8", 64'(lat), 64'(8));
    check("busy_done", 64'(busy8), 64'(1'b1));
    if (retire) begin
      step();
      #1;
      check("idle_ready", 64'(ir8), 64'(1'b1));
      check("idle_valid", 64'(ov8), 64'(1'b0));
      check("idle_busy", 64'(busy8), 64'(1'b0));
    end
  endtask

  task automatic run_w1();
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v    = 3'(i);
      iv1  = 1'b1;
      a1   = v[2];
      b1   = v[1];
      cin1 = v[0];
      q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      step();
      iv1 = 1'b0;
      check("w1_run_no_valid", 64'(ov1), 64'(1'b0));
      check("w1_run_busy", 64'(busy1), 64'(1'b1));
      step();
      check("w1_latency_valid", 64'(ov1), 64'(1'b1));
      step();
      check("w1_idle_ready", 64'(ir1), 64'(1'b1));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(ir8), 64'(1'b1));
    check({tag, "_out_valid"}, 64'(ov8), 64'(1'b0));
    check({tag, "_busy"}, 64'(busy8), 64'(1'b0));
    check({tag, "_sum"}, 64'(sum8), 64'(8'h00));
    check({tag, "_cout"}, 64'(cout8), 64'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
    step();
    step();
    check_reset_vals("reset");
    check("reset_w1_valid", 64'(ov1), 64'(1'b0));
    rst_n = 1'b1;
    step();

    // Directed adds, including full carry chains.
    op8(8'h3C, 8'h05, 1'b0, 1'b1);
    op8(8'hFF, 8'h01, 1'b0, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, 1'b1);

    // Backpressure: result held, new operands refused.
    or8 = 1'b0;
    op8(8'h12, 8'h34, 1'b1, 1'b0);
    hold_v = {cout8, sum8};
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1;
      a8  = 8'h11;
      b8  = 8'h22;
      #1;
      check("bp_valid", 64'(ov8), 64'(1'b1));
      check("bp_in_ready", 64'(ir8), 64'(1'b0));
      check("bp_hold", 64'({cout8, sum8}), 64'(hold_v));
      step();
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    step();
    #1;
    check("bp_release_valid", 64'(ov8), 64'(1'b0));
    check("bp_not_taken", 64'(busy8), 64'(1'b0));

    // Back-to-back: retire and accept on the same edge.
    op8(8'h55, 8'h66, 1'b0, 1'b0);
    op8(8'h10, 8'h20, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN.
    iv8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
    step();
    iv8 = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    step();
    rst_n = 1'b1;
    step();
    op8(8'h7F, 8'h01, 1'b0, 1'b1);

    // Degenerate one-bit instance, all input combinations.
    run_w1();

    // Randomized operands, mixing idle gaps and back-to-back transfers.
    for (int i = 0; i < 30; i++) begin
      or8 = 1'b1;
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step();
    step();

    check("q8_drained", 64'(q8.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer that time-shares one 1-bit full adder (two half_adder cells plus an OR) across a WIDTH-bit add. It accepts operands on a valid/ready handshake and walks them LSB-first through the adder, one bit per clock, holding the carry in a register. It returns the result on a second valid/ready handshake. It sits between a requester (test stimulus or upstream logic) and the shared adder cell, trading latency for area.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  requester presents a, b, cin
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A, sampled only on the accept edge
b  input  WIDTH  operand B, sampled only on the accept edge
cin  input  1  carry-in, sampled only on the accept edge
out_valid  output  1  sum/cout hold a completed result
out_ready  input  1  consumer takes the result
sum  output  WIDTH  result bits
cout  output  1  final carry-out
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous, immediate): state=IDLE; operand shift registers, sum, cout, carry and bit counter all 0. Outputs during reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- State machine: IDLE, RUN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - load a and b into shift registers; carry<=cin; cnt<=0; go to RUN.
- RUN: in_ready=0, out_valid=0. Each edge:
  - full adder computes (a_sh[0], b_sh[0], carry); a_sh and b_sh shift right.
  - the sum bit enters sum at the MSB while sum shifts right, so after WIDTH edges bit i sits at sum[i].
  - carry<=adder carry-out; cnt<=cnt+1.
  - on the edge processing cnt==WIDTH-1: cout<=adder carry-out; go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE: out_valid=1; sum and cout are stable.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: result retires and new operands are accepted on the same edge; go directly to RUN.
  - out_ready=0: hold DONE indefinitely with all outputs frozen.
- in_ready = (state==IDLE) | (state==DONE & out_ready). The combinational path out_ready->in_ready is intentional.
- Latency: out_valid rises WIDTH cycles after the accept edge. Back-to-back throughput is one result per WIDTH+1 cycles.
- sum/cout are meaningful only while out_valid=1. During RUN, sum shows partial shift contents; the bench must not check it then.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- cnt width: max(1, clog2(WIDTH)). WIDTH=1: RUN is one cycle, and the first RUN edge is also the last.
- in_valid while in_ready=0: ignored; a/b/cin are not sampled; no error.
- Reset mid-RUN or mid-DONE: the in-flight operation is discarded, nothing is reported, and the block returns to IDLE values immediately.

Decomposition:
- Shared package serial_add_pkg: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the count-width helper function.
- One sub-module, full_adder: two existing half_adder instances plus an OR for carry-out.
- The controller instantiates exactly one full_adder.

Test Plan:
- Basic add: WIDTH=8, a=8'h3C, b=8'h05, cin=0, out_ready=1 -> out_valid rises 8 cycles after accept; sum=8'h41, cout=0; busy high for 9 cycles.
- Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with a=8'h11 -> out_valid, sum and cout stay constant; in_ready=0; new operands are not taken. Release out_ready -> the prior result retires.
- Back-to-back: in DONE drive out_ready=1 and in_valid=1 (a=8'h10, b=8'h20) -> accepted on the same edge; out_valid low for exactly 8 cycles, then sum=8'h30.
- Reset mid-RUN: assert rst_n=0 after 3 RUN cycles -> outputs go to their reset values immediately without waiting for a clock edge. After release, a=8'h7F, b=8'h01 -> sum=8'h80, cout=0.
- Degenerate width: WIDTH=1 instance, a=1, b=1, cin=1 -> out_valid one cycle after accept; sum=1, cout=1.
